// File: rtl/fifo_ram_param.sv
// rtl/fifo_ram_param.sv - parameterised RAM-backed synchronous FIFO with registered read port
module fifo_ram_param #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int AF_TH      = 60,
    parameter int AE_TH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_TH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  err_ov_q, err_ov_d;
    logic                  err_un_q, err_un_d;
    logic                  push_ok, pop_ok;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (AE_TH >= 0) && (count_q <= AE_C);

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        err_ov_d   = err_ov_q || (push && full && !pop);
        err_un_d   = err_un_q || (pop && empty);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem[rd_ptr_q];
            valid_d    = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_ov_q   <= 1'b0;
            err_un_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_ov_q   <= err_ov_d;
            err_un_q   <= err_un_d;
        end
    end

    // Storage is never reset; only entries already written can reach data_out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out      = data_out_q;
    assign valid_out     = valid_q;
    assign count         = count_q;
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_un_q;

endmodule

// File: tb/tb_fifo_ram_param.sv
// tb/tb_fifo_ram_param.sv - randomised queue-model bench for fifo_ram_param
module tb_fifo_ram_param;

    logic       clk;
    logic       reset_L;
    logic       push;
    logic       pop;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       valid_out;
    logic [6:0] count;
    logic       full, empty, almost_full, almost_empty;
    logic       err_overflow, err_underflow;

    int vectors    = 0;
    int miscompares = 0;

    fifo_ram_param dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [3:0] m_q[$];
    logic [3:0] m_dout  = '0;
    logic       m_valid = 1'b0;
    logic       m_ov    = 1'b0;
    logic       m_un    = 1'b0;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ov    = 1'b0;
            m_un    = 1'b0;
        end else begin
            bit was_full, was_empty, push_acc, pop_acc;
            was_full  = (m_q.size() == 64);
            was_empty = (m_q.size() == 0);
            push_acc  = push && (!was_full || pop);
            pop_acc   = pop && !was_empty;
            if (push && was_full && !pop) m_ov = 1'b1;
            if (pop && was_empty) m_un = 1'b1;
            m_valid = pop_acc;
            if (pop_acc) m_dout = m_q.pop_front();
            if (push_acc) m_q.push_back(data_in);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("data_out",      32'(data_out),      32'(m_dout));
        check("valid_out",     32'(valid_out),     32'(m_valid));
        check("count",         32'(count),         32'(m_q.size()));
        check("full",          32'(full),          32'(m_q.size() == 64));
        check("empty",         32'(empty),         32'(m_q.size() == 0));
        check("almost_full",   32'(almost_full),   32'(m_q.size() >= 60));
        check("almost_empty",  32'(almost_empty),  32'(m_q.size() <= 4));
        check("err_overflow",  32'(err_overflow),  32'(m_ov));
        check("err_underflow", 32'(err_underflow), 32'(m_un));
    end

    task automatic step(input logic p, input logic q, input logic [3:0] d);
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic pin_reset_values(input string tag);
        check({tag, "_count"},    32'(count),         32'd0);
        check({tag, "_dout"},     32'(data_out),      32'd0);
        check({tag, "_valid"},    32'(valid_out),     32'd0);
        check({tag, "_empty"},    32'(empty),         32'd1);
        check({tag, "_full"},     32'(full),          32'd0);
        check({tag, "_af"},       32'(almost_full),   32'd0);
        check({tag, "_ae"},       32'(almost_empty),  32'd1);
        check({tag, "_ov"},       32'(err_overflow),  32'd0);
        check({tag, "_un"},       32'(err_underflow), 32'd0);
    endtask

    initial begin
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        reset_L = 1'b1;
        #1 reset_L = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pin_reset_values("por");
        reset_L = 1'b1;

        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 4'(i));
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 4'h0);
            check("s36_valid", 32'(valid_out), 32'd1);
            check("s36_dout",  32'(data_out),  32'(i));
        end
        step(1'b0, 1'b0, 4'h0);
        check("s36_valid_drop", 32'(valid_out), 32'd0);
        check("s36_count",      32'(count),     32'd0);
        check("s36_empty",      32'(empty),     32'd1);

        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 4'(i % 16));
            if (i == 58) check("s37_af_59", 32'(almost_full), 32'd0);
            if (i == 59) check("s37_af_60", 32'(almost_full), 32'd1);
        end
        check("s37_full",  32'(full),  32'd1);
        check("s37_count", 32'(count), 32'd64);
        step(1'b1, 1'b0, 4'h7);
        check("s37_ov",    32'(err_overflow), 32'd1);
        check("s37_count_hold", 32'(count),   32'd64);

        step(1'b1, 1'b1, 4'hA);
        check("s38_dout",  32'(data_out), 32'h0);
        check("s38_count", 32'(count),    32'd64);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 4'h0);
        check("s38_dout_63", 32'(data_out), 32'hF);
        step(1'b0, 1'b1, 4'h0);
        check("s38_dout_A",  32'(data_out), 32'hA);
        check("s38_empty",   32'(empty),    32'd1);

        step(1'b0, 1'b1, 4'h0);
        check("s39_un",    32'(err_underflow), 32'd1);
        check("s39_valid", 32'(valid_out),     32'd0);
        check("s39_count", 32'(count),         32'd0);
        step(1'b1, 1'b1, 4'h5);
        check("s39_count_pp", 32'(count),         32'd1);
        check("s39_un_pp",    32'(err_underflow), 32'd1);
        check("s39_valid_pp", 32'(valid_out),     32'd0);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'($urandom));
        check("s40_ae_5", 32'(almost_empty), 32'd0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 4'($urandom));
        check("s40_count", 32'(count), 32'd5);
        step(1'b0, 1'b1, 4'h0);
        check("s40_ae_4", 32'(almost_empty), 32'd1);

        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'($urandom));
        check("s41_count_10", 32'(count), 32'd10);
        step(1'b0, 1'b1, 4'h0);
        #3 reset_L = 1'b0;
        #1;
        pin_reset_values("async");
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;

        for (int ph = 0; ph < 15; ph++) begin
            int pp, qp;
            pp = $urandom_range(10, 90);
            qp = $urandom_range(10, 90);
            for (int c = 0; c < 200; c++) begin
                step(1'($urandom_range(0, 99) < pp),
                     1'($urandom_range(0, 99) < qp),
                     4'($urandom));
            end
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
